mult_pipe: RTL and testbench

Parametrised, fully pipelined multiplier for two W-bit operands, signed or unsigned per transaction, producing a 2W-bit product. It is the next generation of the team's fixed 8-bit signed pipelined multiplier and adds a valid/ready handshake with backpressure, a per-beat signed/unsigned mode, a pass-through tag and an optional accumulate stage. It sits between operand producers (datapath FSMs) and result consumers, and accepts one beat per cycle when not stalled.

---
 rtl/mult_pipe.sv | 184 ++++++++++++++++++
 tb/tb_mult_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// mult_pipe: fully pipelined W x W multiplier, signed or unsigned per beat,
// with valid/ready handshake, global stall and a pass-through tag.
// Optional accumulate stage enabled by defining MULT_ACC_EN.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready = advance)
//   in_a, in_b            W-bit operands
//   in_signed             1: both operands two's complement, 0: unsigned
//   in_tag                sideband returned with the result
//   out_valid / out_ready result beat handshake
//   out_p                 2W-bit product
//   out_tag               tag of the beat on out_p
//   in_acc, out_acc       (MULT_ACC_EN only) accumulate control / running sum
module mult_pipe #(
   parameter int unsigned W     = 8,
   parameter int unsigned PPS   = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef MULT_ACC_EN
   input  logic               in_acc,
   output logic [2*W+3:0]     out_acc,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W-1:0]     out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int unsigned N   = W / PPS;
   localparam int unsigned P2W = 2 * W;
`ifdef MULT_ACC_EN
   localparam int unsigned AW  = 2 * W + 4;
`endif

   // Global stall: every stage moves together or holds together
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage 0 inputs: operand magnitudes and result sign
   logic [W-1:0] a_mag_c;
   logic [W-1:0] b_mag_c;
   logic         sgn_c;

   always_comb begin
      a_mag_c = in_a;
      b_mag_c = in_b;
      sgn_c   = in_signed & (in_a[W-1] ^ in_b[W-1]);
      if (in_signed && in_a[W-1]) a_mag_c = ~in_a + W'(1);
      if (in_signed && in_b[W-1]) b_mag_c = ~in_b + W'(1);
   end

   // Pipeline registers; index 0 is the input register, 1..N accumulate.
   // sum_q[0] is held at zero so every accumulation stage has the same form.
   logic [W-1:0]     a_mag_q [0:N-1];
   logic [W-1:0]     b_mag_q [0:N-1];
   logic [P2W-1:0]   sum_q   [0:N];
   logic [TAG_W-1:0] tag_q   [0:N];
   logic [N:0]       sgn_q;
   logic [N:0]       vld_q;
`ifdef MULT_ACC_EN
   logic [N:0]       md_q;
   logic [N:0]       accf_q;
`endif

   // Final (negation) stage
   logic             fin_vld;
   logic [P2W-1:0]   fin_p;
   logic [TAG_W-1:0] fin_tag;
`ifdef MULT_ACC_EN
   logic             fin_md;
   logic             fin_accf;
`endif

   // Stage k adds PPS shifted partial products of the magnitudes
   logic [P2W-1:0] sum_nxt [1:N];

   always_comb begin
      for (int unsigned k = 1; k <= N; k++) begin
         sum_nxt[k] = sum_q[k-1];
         for (int unsigned i = 0; i < PPS; i++) begin
            if (b_mag_q[k-1][(k-1)*PPS + i])
               sum_nxt[k] = sum_nxt[k] + (P2W'(a_mag_q[k-1]) << ((k-1)*PPS + i));
         end
      end
   end

   // Pipeline advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N; k++) begin
            a_mag_q[k] <= '0;
            b_mag_q[k] <= '0;
         end
         for (int unsigned k = 0; k <= N; k++) begin
            sum_q[k] <= '0;
            tag_q[k] <= '0;
         end
         sgn_q   <= '0;
         vld_q   <= '0;
         fin_vld <= 1'b0;
         fin_p   <= '0;
         fin_tag <= '0;
`ifdef MULT_ACC_EN
         md_q     <= '0;
         accf_q   <= '0;
         fin_md   <= 1'b0;
         fin_accf <= 1'b0;
`endif
      end else if (advance) begin
         vld_q[0]   <= in_valid;
         a_mag_q[0] <= a_mag_c;
         b_mag_q[0] <= b_mag_c;
         sgn_q[0]   <= sgn_c;
         tag_q[0]   <= in_tag;
         sum_q[0]   <= '0;
`ifdef MULT_ACC_EN
         md_q[0]    <= in_signed;
         accf_q[0]  <= in_acc;
`endif
         for (int unsigned k = 1; k < N; k++) begin
            a_mag_q[k] <= a_mag_q[k-1];
            b_mag_q[k] <= b_mag_q[k-1];
         end
         for (int unsigned k = 1; k <= N; k++) begin
            sum_q[k] <= sum_nxt[k];
            sgn_q[k] <= sgn_q[k-1];
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
`ifdef MULT_ACC_EN
            md_q[k]   <= md_q[k-1];
            accf_q[k] <= accf_q[k-1];
`endif
         end
         fin_vld <= vld_q[N];
         fin_p   <= sgn_q[N] ? (~sum_q[N] + P2W'(1)) : sum_q[N];
         fin_tag <= tag_q[N];
`ifdef MULT_ACC_EN
         fin_md   <= md_q[N];
         fin_accf <= accf_q[N];
`endif
      end
   end

`ifdef MULT_ACC_EN
   // Accumulate stage: outputs re-registered so acc stays aligned with out_p
   logic [AW-1:0] acc_q;
   logic [AW-1:0] ext_c;

   assign ext_c   = {{4{fin_md & fin_p[P2W-1]}}, fin_p};
   assign out_acc = acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_tag   <= '0;
         acc_q     <= '0;
      end else begin
         if (advance) begin
            out_valid <= fin_vld;
            out_p     <= fin_p;
            out_tag   <= fin_tag;
         end
         if (advance && fin_vld)
            acc_q <= (fin_accf ? acc_q : AW'(0)) + ext_c;
      end
   end
`else
   assign out_valid = fin_vld;
   assign out_p     = fin_p;
   assign out_tag   = fin_tag;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: expected results are queued at accept time
// and a negedge monitor pops and compares each delivered beat.
module tb_mult_pipe;

   localparam int unsigned W     = 8;
   localparam int unsigned PPS   = 2;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned P2W   = 2 * W;
   localparam int unsigned AW    = 2 * W + 4;
`ifdef MULT_ACC_EN
   localparam int unsigned LAT = W / PPS + 3;
`else
   localparam int unsigned LAT = W / PPS + 2;
`endif

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       in_a;
   logic [W-1:0]       in_b;
   logic               in_signed;
   logic [TAG_W-1:0]   in_tag;
   logic               in_acc;
   logic               out_valid;
   logic               out_ready;
   logic [P2W-1:0]     out_p;
   logic [TAG_W-1:0]   out_tag;
`ifdef MULT_ACC_EN
   logic [AW-1:0]      out_acc;
`endif

   mult_pipe #(.W(W), .PPS(PPS), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_tag    (in_tag),
`ifdef MULT_ACC_EN
      .in_acc    (in_acc),
      .out_acc   (out_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag)
   );

   typedef struct packed {
      logic [P2W-1:0]   p;
      logic [TAG_W-1:0] tag;
      logic [AW-1:0]    acc;
   } exp_t;

   exp_t           sb[$];
   exp_t           drv_exp;
   int             n_cmp = 0;
   int             n_bad = 0;
   int             beats_out = 0;
   logic [AW-1:0]  acc_model = '0;
   bit             rand_ready = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Consumer side: random or always-ready, changed just after each edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard push on accept, pop/compare on consume, stall stability
   bit             held = 0;
   logic [P2W-1:0] held_p;
   logic [TAG_W-1:0] held_tag;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         held = 0;
      end else begin
         if (held) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_p", 64'(out_p), 64'(held_p));
            check("stall_tag", 64'(out_tag), 64'(held_tag));
         end
         held     = out_valid && !out_ready;
         held_p   = out_p;
         held_tag = out_tag;
         if (in_valid && in_ready) sb.push_back(drv_exp);
         if (out_valid && out_ready) begin
            beats_out++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got p=0x%0h tag=0x%0h, expected no beat", out_p, out_tag);
            end else begin
               e = sb.pop_front();
               check("out_p", 64'(out_p), 64'(e.p));
               check("out_tag", 64'(out_tag), 64'(e.tag));
`ifdef MULT_ACC_EN
               check("out_acc", 64'(out_acc), 64'(e.acc));
`endif
            end
         end
      end
   end

   // Drive one beat and hold it until accepted
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TAG_W-1:0] t, input logic ac,
                       input logic [P2W-1:0] ep, input logic [AW-1:0] ea);
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = t;
      in_acc    = ac;
      in_valid  = 1'b1;
      drv_exp   = '{p: ep, tag: t, acc: ea};
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 1000 cycles, expected 1");
   endtask

   // Reference: plain integer product; accumulator as modular running sum
   task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TAG_W-1:0] t, input logic ac,
                       input bit use_cp, input logic [P2W-1:0] cp,
                       input bit use_ca, input logic [AW-1:0] ca);
      longint av, bv, prod;
      logic [P2W-1:0] ep;
      if (s) begin
         av = longint'($signed(a));
         bv = longint'($signed(b));
      end else begin
         av = longint'(a);
         bv = longint'(b);
      end
      prod      = av * bv;
      ep        = use_cp ? cp : P2W'(prod);
      acc_model = (ac ? acc_model : AW'(0)) + AW'(prod);
      if (use_ca) acc_model = ca;
      send(a, b, s, t, ac, ep, acc_model);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   int k;
   int mark;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      in_tag    = '0;
      in_acc    = 1'b0;
      drv_exp   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_p", 64'(out_p), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      rst_n = 1'b1;

      // Latency with an empty pipe and out_ready held high
      beat(8'd3, 8'd5, 1'b0, 4'h1, 1'b0, 0, '0, 0, '0);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("latency", 64'(k), 64'(LAT - 1));
      drain();

      // Signed and unsigned corners, back-to-back
      beat(8'h80, 8'h80, 1'b1, 4'h2, 1'b0, 1, 16'h4000, 0, '0);
      beat(8'hFF, 8'h7F, 1'b1, 4'h3, 1'b0, 1, 16'hFF81, 0, '0);
      beat(8'h80, 8'h7F, 1'b1, 4'h4, 1'b0, 1, 16'hC080, 0, '0);
      beat(8'h00, 8'hFB, 1'b1, 4'h5, 1'b0, 1, 16'h0000, 0, '0);
      beat(8'hFF, 8'hFF, 1'b0, 4'h6, 1'b0, 1, 16'hFE01, 0, '0);
      beat(8'h80, 8'h02, 1'b0, 4'h7, 1'b0, 1, 16'h0100, 0, '0);
      beat(8'h80, 8'h02, 1'b1, 4'h8, 1'b0, 1, 16'hFF00, 0, '0);
      in_valid = 1'b0;
      drain();

      // Random operands under random backpressure
      rand_ready = 1;
      for (int i = 0; i < 20; i++)
         beat(W'($urandom), W'($urandom), 1'($urandom), TAG_W'($urandom), 1'($urandom),
              0, '0, 0, '0);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      rand_ready = 0;
      drain();

      // Accumulate sequence with fixed expected running sums
      beat(8'd3, 8'd4, 1'b1, 4'h9, 1'b0, 0, '0, 1, 20'd12);
      beat(8'd5, 8'd6, 1'b1, 4'hA, 1'b1, 0, '0, 1, 20'd42);
      beat(8'hFE, 8'd7, 1'b1, 4'hB, 1'b1, 0, '0, 1, 20'd28);
      beat(8'd1, 8'd1, 1'b1, 4'hC, 1'b0, 0, '0, 1, 20'd1);
      in_valid = 1'b0;
      drain();

      // Reset mid-pipeline: in-flight beats must vanish
      beat(8'd9, 8'd9, 1'b0, 4'hD, 1'b0, 0, '0, 0, '0);
      beat(8'd7, 8'd2, 1'b0, 4'hE, 1'b0, 0, '0, 0, '0);
      beat(8'd4, 8'd4, 1'b0, 4'hF, 1'b0, 0, '0, 0, '0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_p", 64'(out_p), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      acc_model = '0;
      mark      = beats_out;
      repeat (20) @(posedge clk);
      #1;
      check("no_stale_beat", 64'(beats_out - mark), 64'd0);

      // Pipe usable again after reset
      beat(8'h85, 8'h03, 1'b1, 4'h6, 1'b0, 0, '0, 0, '0);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
